// File: rtl/dac_pkg.sv
//------------------------------------------------------------------------------
// Module  : dac_pkg
// Brief   : Shared types and constants for the DAC playback controller.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dac_state_e;

  localparam logic [7:0] DAC_IDLE_CODE = 8'h80;
  // Smallest usable rate_div; yields the minimum period of two mclk cycles.
  localparam int         DAC_MIN_DIV   = 1;

endpackage

`default_nettype wire

// File: rtl/dac_sample_fifo.sv
//------------------------------------------------------------------------------
// Module  : dac_sample_fifo
// Brief   : Synchronous sample FIFO, depth 2**ADDR_W, registered occupancy.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dac_sample_fifo #(
  parameter int ADDR_W = 4,
  parameter int DW     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic              pop_i,
  output logic [DW-1:0]     rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              w_push, w_pop;

  assign full_o    = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dac_playback_ctrl.sv
//------------------------------------------------------------------------------
// Module  : dac_playback_ctrl
// Brief   : Buffers processor samples and plays them to the DAC at rate_div+1.
//           Optional underrun event counter when DAC_UNDERRUN_CNT_EN is defined.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dac_playback_ctrl
  import dac_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter int         DIV_W     = 16,
  parameter int         PRIME_LVL = 8,
  parameter logic [7:0] IDLE_CODE = DAC_IDLE_CODE
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [ADDR_W:0]  level,
  output logic             running,
  output logic             underrun,
  input  logic             clr_underrun,
  output logic [7:0]       dac_data,
  output logic             dac_clk
`ifdef DAC_UNDERRUN_CNT_EN
  , output logic [15:0]    underrun_cnt
`endif
);

  localparam int              DEPTH       = 1 << ADDR_W;
  localparam int              PRIME_EFF_I = (PRIME_LVL > DEPTH) ? DEPTH : PRIME_LVL;
  localparam logic [ADDR_W:0] PRIME_EFF   = PRIME_EFF_I[ADDR_W:0];

  dac_state_e       state_q, state_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] lim_q, lim_d;
  logic [7:0]       dac_data_q, dac_data_d;
  logic             dac_clk_q, dac_clk_d;
  logic             underrun_q, underrun_d;
  logic             w_pop, w_urun_evt;
  logic [7:0]       w_head;
  logic             w_full, w_empty;
  logic [ADDR_W:0]  w_level;
  logic [DIV_W-1:0] w_lim_new;
  logic [DIV_W:0]   w_half;

  dac_sample_fifo #(.ADDR_W(ADDR_W), .DW(8)) u_fifo (
    .clk_i     (mclk),
    .rst_i     (rst),
    .push_i    (wr_valid),
    .wr_data_i (wr_data),
    .pop_i     (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (w_level)
  );

  // lim holds P-1; zero divider is promoted to the minimum period.
  assign w_lim_new = (rate_div == '0) ? DIV_W'(DAC_MIN_DIV) : rate_div;
  assign w_half    = ({1'b0, lim_q} + (DIV_W+1)'(1)) >> 1;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    lim_d      = lim_q;
    dac_data_d = dac_data_q;
    dac_clk_d  = dac_clk_q;
    underrun_d = underrun_q & ~clr_underrun;
    w_pop      = 1'b0;
    w_urun_evt = 1'b0;
    if (!enable) begin
      state_d    = ST_IDLE;
      ph_d       = '0;
      dac_data_d = IDLE_CODE;
      dac_clk_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_PRIME;
          ph_d       = '0;
          dac_data_d = IDLE_CODE;
          dac_clk_d  = 1'b0;
        end
        ST_PRIME: begin
          ph_d       = '0;
          dac_data_d = IDLE_CODE;
          dac_clk_d  = 1'b0;
          if ((w_level >= PRIME_EFF) || w_full) begin
            state_d = ST_RUN;
            lim_d   = w_lim_new;
          end
        end
        ST_RUN: begin
          dac_clk_d = (ph_q != '0) && ({1'b0, ph_q} <= w_half);
          if (ph_q == lim_q) begin
            ph_d  = '0;
            lim_d = w_lim_new;
          end else begin
            ph_d = ph_q + DIV_W'(1);
          end
          if (ph_q == '0) begin
            if (!w_empty) begin
              w_pop      = 1'b1;
              dac_data_d = w_head;
            end else begin
              w_urun_evt = 1'b1;
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      lim_q      <= DIV_W'(DAC_MIN_DIV);
      dac_data_q <= IDLE_CODE;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      lim_q      <= lim_d;
      dac_data_q <= dac_data_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
    end
  end

  assign wr_ready = ~w_full;
  assign level    = w_level;
  assign running  = (state_q == ST_RUN);
  assign underrun = underrun_q;
  assign dac_data = dac_data_q;
  assign dac_clk  = dac_clk_q;

`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // A new event in the clearing cycle leaves the count at exactly one.
  always_comb begin
    cnt_d = clr_underrun ? 16'd0 : cnt_q;
    if (w_urun_evt) begin
      if (clr_underrun)          cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_playback_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_dac_playback_ctrl
// Brief   : Self-checking bench for dac_playback_ctrl with a queue-based model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dac_playback_ctrl;

  localparam int ADDR_W = 4;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 16;
  localparam int PRIME  = 8;
  localparam int S_IDLE = 0, S_PRIME = 1, S_RUN = 2;

  logic             mclk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] rate_div = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             clr_underrun = 1'b0;
  logic             wr_ready, running, underrun, dac_clk;
  logic [ADDR_W:0]  level;
  logic [7:0]       dac_data;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dac_playback_ctrl #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .PRIME_LVL(PRIME), .IDLE_CODE(8'h80)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .level        (level),
    .running      (running),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .dac_data     (dac_data),
    .dac_clk      (dac_clk)
`ifdef DAC_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample queue plus the playback rules in terms of period P.
  bit         m_valid = 0;
  int         m_state, m_ph, m_per, m_cnt;
  logic [7:0] mq[$];
  logic [7:0] m_data;
  bit         m_clk, m_urun;

  function automatic int period_of(input logic [DIV_W-1:0] rd);
    return (rd == 0) ? 2 : int'(rd) + 1;
  endfunction

  task automatic model_step();
    int lvl;
    bit full, acc, evt;
    if (rst) begin
      m_valid = 1; m_state = S_IDLE; mq.delete(); m_ph = 0; m_per = 2;
      m_data = 8'h80; m_clk = 0; m_urun = 0; m_cnt = 0;
      return;
    end
    if (!m_valid) return;
    lvl  = mq.size();
    full = (lvl == DEPTH);
    acc  = wr_valid && !full;
    evt  = 0;
    if (!enable || m_state != S_RUN) begin
      if (!enable)                  m_state = S_IDLE;
      else if (m_state == S_IDLE)   m_state = S_PRIME;
      else if (lvl >= PRIME || full) begin
        m_state = S_RUN;
        m_per   = period_of(rate_div);
      end
      m_ph = 0; m_data = 8'h80; m_clk = 0;
    end else begin
      m_clk = (m_ph >= 1) && (m_ph <= m_per / 2);
      if (m_ph == 0) begin
        if (lvl > 0) m_data = mq.pop_front();
        else         evt = 1;
      end
      m_ph++;
      if (m_ph == m_per) begin
        m_ph  = 0;
        m_per = period_of(rate_div);
      end
    end
    m_urun = evt ? 1'b1 : (m_urun && !clr_underrun);
    if (evt) m_cnt = clr_underrun ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
    else if (clr_underrun) m_cnt = 0;
    if (acc) mq.push_back(wr_data);
  endtask

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge mclk) begin
    if (m_valid) begin
      chk("dac_data", dac_data, m_data);
      chk("dac_clk",  dac_clk,  m_clk);
      chk("level",    level,    mq.size());
      chk("wr_ready", wr_ready, mq.size() < DEPTH);
      chk("running",  running,  m_state == S_RUN);
      chk("underrun", underrun, m_urun);
`ifdef DAC_UNDERRUN_CNT_EN
      chk("underrun_cnt", underrun_cnt, m_cnt);
`endif
    end
    model_step();
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    tick(); tick();
    chk("rst_data", dac_data, 8'h80);
    chk("rst_clk", dac_clk, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_running", running, 0);
    rst = 1'b0;

    // Priming: seven samples keep PRIME, the eighth releases RUN.
    enable = 1'b1; rate_div = 16'd3;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = 8'((i + 1) * 16); tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    chk("prime_hold", running, 0);
    wr_valid = 1'b1; wr_data = 8'h80; tick(); wr_valid = 1'b0;
    k = 0;
    while (!running && k < 2) begin tick(); k++; end
    chk("prime_run", running, 1);

    // Period 4: data every 4 cycles, dac_clk high 2 cycles starting one after the change.
    k = 0;
    while (dac_data == 8'h80 && k < 20) begin tick(); k++; end
    chk("first_sample", dac_data, 8'h10);
    chk("clk_p0", dac_clk, 0); tick();
    chk("clk_p1", dac_clk, 1); tick();
    chk("clk_p2", dac_clk, 1); tick();
    chk("clk_p3", dac_clk, 0); tick();
    chk("period4_sample", dac_data, 8'h20);

    // Underrun after draining, clear, and re-set on the next due sample.
    k = 0;
    while (!underrun && k < 60) begin tick(); k++; end
    chk("underrun_set", underrun, 1);
    chk("underrun_hold", dac_data, 8'h80);
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    chk("underrun_clr", underrun, 0);
    k = 0;
    while (!underrun && k < 8) begin tick(); k++; end
    chk("underrun_reset", underrun, 1);

    enable = 1'b0; tick();
    chk("dis_data", dac_data, 8'h80);
    chk("dis_clk", dac_clk, 0);
    chk("dis_running", running, 0);

    // Full: 17 writes while disabled, the last one is dropped.
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hA0 + i); tick();
    end
    wr_valid = 1'b0;
    chk("full_level", level, 16);
    chk("full_ready", wr_ready, 0);

    // rate_div=0 behaves as period 2.
    enable = 1'b1; rate_div = '0;
    k = 0;
    while (dac_data == 8'h80 && k < 10) begin tick(); k++; end
    chk("p2_first", dac_data, 8'hA0);
    tick(); tick();
    chk("p2_second", dac_data, 8'hA1);

    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_data", dac_data, 8'h80);
    chk("midrst_level", level, 0);
    chk("midrst_running", running, 0);
    chk("midrst_clk", dac_clk, 0);

    // Randomised traffic checked cycle by cycle against the model.
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) rate_div = DIV_W'($urandom_range(0, 5));
      wr_valid     = ($urandom_range(0, 2) != 0);
      wr_data      = 8'($urandom);
      clr_underrun = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; wr_valid = 1'b0; clr_underrun = 1'b0; enable = 1'b0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
